inst_fetch_queue: RTL and testbench

//  Parametrised instruction fetch unit: issues sequential PC reads to the instruction

---
 rtl/inst_fetch_queue.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: sequential icache reads, FIFO of {pc, inst} to decode, redirect flush.
// Optional macro FETCH_JAL_PREDICT_EN: follow JAL targets when computing the next fetch PC.
module inst_fetch_queue #(
  parameter int INST_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 17,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         icache_read_valid,
  output logic [ADDR_WIDTH-1:0]        icache_read_addr,
  input  logic                         icache_read_done,
  input  logic [INST_WIDTH-1:0]        icache_read_data,
  output logic                         decode_valid,
  output logic [INST_WIDTH-1:0]        decode_inst,
  output logic [ADDR_WIDTH-1:0]        decode_pc,
  input  logic                         decode_ready,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  logic [1:0]            state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_nxt_s;
  logic [ADDR_WIDTH-1:0] req_addr_r, req_addr_nxt_s;
  logic [ADDR_WIDTH-1:0] next_pc_s;
  logic [PTR_W-1:0]      head_r, tail_r;
  logic [CNT_W-1:0]      count_r, count_nxt_s, count_after_pop_s;
  logic [ADDR_WIDTH-1:0] pc_mem_r   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_r [QUEUE_DEPTH];
  logic                  pop_s, push_s, issue_s;

`ifdef FETCH_JAL_PREDICT_EN
  function automatic logic [ADDR_WIDTH-1:0] jal_target(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [INST_WIDTH-1:0] inst);
    logic [31:0] imm;
    logic [31:0] sum;
    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    sum = 32'(base) + imm;
    return sum[ADDR_WIDTH-1:0];
  endfunction
`endif

  // A pop frees its slot in the same cycle, so issue is judged against the post-pop count.
  assign pop_s             = (count_r != {CNT_W{1'b0}}) && decode_ready;
  assign count_after_pop_s = count_r - {{(CNT_W-1){1'b0}}, pop_s};
  assign issue_s           = (state_r == ST_IDLE) && !redirect_valid && (count_after_pop_s < DEPTH_C);
  assign push_s            = (state_r == ST_WAIT) && icache_read_done && !redirect_valid;

  // Fetch PC that follows the instruction being returned
  always_comb begin
    next_pc_s = pc_r + ADDR_WIDTH'(3'd4);
`ifdef FETCH_JAL_PREDICT_EN
    if (icache_read_data[6:0] == 7'b1101111) begin
      next_pc_s = jal_target(req_addr_r, icache_read_data);
    end else begin
      next_pc_s = pc_r + ADDR_WIDTH'(3'd4);
    end
`endif
  end

  // Next-state, PC and occupancy; a redirect overrides normal sequencing
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    req_addr_nxt_s = req_addr_r;
    count_nxt_s    = count_after_pop_s + {{(CNT_W-1){1'b0}}, push_s};
    if (redirect_valid) begin
      pc_nxt_s    = redirect_pc;
      count_nxt_s = {CNT_W{1'b0}};
      case (state_r)
        ST_WAIT, ST_FLUSH: state_nxt_s = icache_read_done ? ST_IDLE : ST_FLUSH;
        default:           state_nxt_s = ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            req_addr_nxt_s = pc_r;
            state_nxt_s    = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (icache_read_done) begin
            pc_nxt_s    = next_pc_s;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_FLUSH: state_nxt_s = icache_read_done ? ST_IDLE : ST_FLUSH;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Control registers, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      count_r    <= {CNT_W{1'b0}};
    end else if (rdy) begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      req_addr_r <= req_addr_nxt_s;
      count_r    <= count_nxt_s;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_r[i]   <= {ADDR_WIDTH{1'b0}};
        inst_mem_r[i] <= {INST_WIDTH{1'b0}};
      end
    end else if (rdy) begin
      if (redirect_valid) begin
        head_r <= {PTR_W{1'b0}};
        tail_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          pc_mem_r[tail_r]   <= req_addr_r;
          inst_mem_r[tail_r] <= icache_read_data;
          tail_r             <= tail_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          head_r <= head_r + PTR_W'(1'b1);
        end
      end
    end
  end

  assign icache_read_valid = (state_r != ST_IDLE);
  assign icache_read_addr  = req_addr_r;
  assign decode_valid      = (count_r != {CNT_W{1'b0}});
  assign decode_pc         = pc_mem_r[head_r];
  assign decode_inst       = inst_mem_r[head_r];
  assign queue_count       = count_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: vector table, corner sequences, random vs. queue model.
module tb_inst_fetch_queue;
  localparam int IW = 32;
  localparam int AW = 17;
  localparam int QD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, rdy, redirect_valid, icache_read_done, decode_ready;
  logic [AW-1:0] redirect_pc;
  logic [IW-1:0] icache_read_data;
  logic          icache_read_valid, decode_valid;
  logic [AW-1:0] icache_read_addr, decode_pc;
  logic [IW-1:0] decode_inst;
  logic [CW-1:0] queue_count;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] inst; } entry_t;
  entry_t        mq[$];
  logic [AW-1:0] m_pc, m_req;
  bit            m_inflight, m_stale;
  int            age;
  bit            resp_en;

  typedef struct {
    bit rdy; bit redir; logic [AW-1:0] rpc; bit done; logic [IW-1:0] data; bit dready;
    bit e_rv; logic [AW-1:0] e_addr; bit e_dv; logic [AW-1:0] e_dpc; logic [IW-1:0] e_inst;
    logic [CW-1:0] e_cnt;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  inst_fetch_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD), .RESET_PC(17'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_read_valid(icache_read_valid), .icache_read_addr(icache_read_addr),
    .icache_read_done(icache_read_done), .icache_read_data(icache_read_data),
    .decode_valid(decode_valid), .decode_inst(decode_inst), .decode_pc(decode_pc),
    .decode_ready(decode_ready), .queue_count(queue_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef FETCH_JAL_PREDICT_EN
  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] base, input logic [IW-1:0] d);
    int n;
    logic signed [20:0] imm;
    n = int'(base) + 4;
    if (d[6:0] == 7'b1101111) begin
      imm = {d[31], d[19:12], d[20], d[30:21], 1'b0};
      n = int'(base) + int'(imm);
    end
    return n[AW-1:0];
  endfunction
`else
  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] base);
    int n;
    n = (int'(base) + 4) % (1 << AW);
    return n[AW-1:0];
  endfunction
`endif

  // Reference behaviour at one clock edge, from the current input values.
  task automatic model_edge();
    bit pop;
    if (!rst) begin
      mq.delete();
      m_pc = '0; m_req = '0; m_inflight = 0; m_stale = 0;
    end else if (rdy) begin
      pop = (mq.size() != 0) && decode_ready;
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc;
        if (m_inflight && icache_read_done) begin
          m_inflight = 0; m_stale = 0;
        end else if (m_inflight) begin
          m_stale = 1;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (!m_inflight) begin
          if (mq.size() < QD) begin
            m_req = m_pc; m_inflight = 1; m_stale = 0;
          end
        end else if (icache_read_done) begin
          if (!m_stale) begin
            mq.push_back('{m_req, icache_read_data});
`ifdef FETCH_JAL_PREDICT_EN
            m_pc = model_next(m_req, icache_read_data);
`else
            m_pc = model_next(m_req);
`endif
          end
          m_inflight = 0; m_stale = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("m_rvalid", 32'(icache_read_valid), 32'(m_inflight));
    if (m_inflight) check("m_raddr", 32'(icache_read_addr), 32'(m_req));
    check("m_dvalid", 32'(decode_valid), 32'(mq.size() != 0));
    check("m_count", 32'(queue_count), 32'(mq.size()));
    if (mq.size() != 0) begin
      check("m_dpc", 32'(decode_pc), 32'(mq[0].pc));
      check("m_dinst", decode_inst, mq[0].inst);
    end
    if (m_inflight) age++; else age = 0;
    if (resp_en) begin
      icache_read_done = m_inflight && (age >= 2);
      icache_read_data = $urandom;
    end
  endtask

  // Redirect and done are held high during reset; reset must still win.
  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; redirect_valid = 1'b1; redirect_pc = 17'h55;
    icache_read_done = 1'b1; icache_read_data = 32'h0; decode_ready = 1'b0; resp_en = 0;
    step(); step();
    check("rst_rvalid", 32'(icache_read_valid), 32'h0);
    check("rst_dvalid", 32'(decode_valid), 32'h0);
    check("rst_count", 32'(queue_count), 32'h0);
    rst = 1'b1; redirect_valid = 1'b0; icache_read_done = 1'b0;
  endtask

  initial begin
    int rises;
    bit prev;
    tbl[0]  = '{1, 0, 17'h0,   0, 32'h0,         1, 1, 17'h0,   0, 17'h0,   32'h0,         3'd0};
    tbl[1]  = '{1, 0, 17'h0,   0, 32'h0,         1, 1, 17'h0,   0, 17'h0,   32'h0,         3'd0};
    tbl[2]  = '{1, 0, 17'h0,   1, 32'hA000_0013, 1, 0, 17'h0,   1, 17'h0,   32'hA000_0013, 3'd1};
    tbl[3]  = '{1, 0, 17'h0,   0, 32'h0,         0, 1, 17'h4,   1, 17'h0,   32'hA000_0013, 3'd1};
    tbl[4]  = '{1, 1, 17'h100, 0, 32'h0,         1, 1, 17'h4,   0, 17'h0,   32'h0,         3'd0};
    tbl[5]  = '{1, 0, 17'h0,   1, 32'hDEAD_0013, 1, 0, 17'h0,   0, 17'h0,   32'h0,         3'd0};
    tbl[6]  = '{1, 0, 17'h0,   0, 32'h0,         1, 1, 17'h100, 0, 17'h0,   32'h0,         3'd0};
    tbl[7]  = '{1, 0, 17'h0,   1, 32'hA100_0013, 0, 0, 17'h0,   1, 17'h100, 32'hA100_0013, 3'd1};
    tbl[8]  = '{1, 0, 17'h0,   0, 32'h0,         0, 1, 17'h104, 1, 17'h100, 32'hA100_0013, 3'd1};
    tbl[9]  = '{1, 0, 17'h0,   1, 32'hA200_0013, 0, 0, 17'h0,   1, 17'h100, 32'hA100_0013, 3'd2};
    tbl[10] = '{1, 0, 17'h0,   0, 32'h0,         0, 1, 17'h108, 1, 17'h100, 32'hA100_0013, 3'd2};
    tbl[11] = '{1, 1, 17'h200, 1, 32'hBEEF_0013, 1, 0, 17'h0,   0, 17'h0,   32'h0,         3'd0};
    tbl[12] = '{1, 0, 17'h0,   0, 32'h0,         1, 1, 17'h200, 0, 17'h0,   32'h0,         3'd0};
    tbl[13] = '{0, 0, 17'h0,   1, 32'hBAD0_0013, 1, 1, 17'h200, 0, 17'h0,   32'h0,         3'd0};
    tbl[14] = '{1, 0, 17'h0,   1, 32'hA300_0013, 1, 0, 17'h0,   1, 17'h200, 32'hA300_0013, 3'd1};
    tbl[15] = '{1, 0, 17'h0,   0, 32'h0,         1, 1, 17'h204, 0, 17'h0,   32'h0,         3'd0};

    age = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rdy = tbl[i].rdy; redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      icache_read_done = tbl[i].done; icache_read_data = tbl[i].data; decode_ready = tbl[i].dready;
      step();
      check($sformatf("vec%0d_rvalid", i), 32'(icache_read_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) check($sformatf("vec%0d_raddr", i), 32'(icache_read_addr), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d_dvalid", i), 32'(decode_valid), 32'(tbl[i].e_dv));
      if (tbl[i].e_dv) begin
        check($sformatf("vec%0d_dpc", i), 32'(decode_pc), 32'(tbl[i].e_dpc));
        check($sformatf("vec%0d_dinst", i), decode_inst, tbl[i].e_inst);
      end
      check($sformatf("vec%0d_count", i), 32'(queue_count), 32'(tbl[i].e_cnt));
    end

    // Backpressure: queue fills to depth, then drains in order and fetch resumes at 0x10.
    do_reset();
    resp_en = 1; rises = 0; prev = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (icache_read_valid && !prev) rises++;
      prev = icache_read_valid;
    end
    check("bp_requests", 32'(rises), 32'd4);
    check("bp_count", 32'(queue_count), 32'd4);
    check("bp_rvalid", 32'(icache_read_valid), 32'h0);
    resp_en = 0; icache_read_done = 1'b0; decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_pop_pc", 32'(decode_pc), 32'(i * 4));
      step();
      if (i == 0) begin
        check("bp_resume_valid", 32'(icache_read_valid), 32'h1);
        check("bp_resume_addr", 32'(icache_read_addr), 32'h10);
      end
    end
    check("bp_drained", 32'(queue_count), 32'h0);

    // PC wrap at the top of the address space.
    do_reset();
    decode_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 17'h1FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_addr_hi", 32'(icache_read_addr), 32'h1FFFC);
    icache_read_done = 1'b1; icache_read_data = 32'h0000_0013;
    step();
    icache_read_done = 1'b0;
    check("wrap_dpc", 32'(decode_pc), 32'h1FFFC);
    step();
    check("wrap_rvalid", 32'(icache_read_valid), 32'h1);
    check("wrap_addr_zero", 32'(icache_read_addr), 32'h0);

    // JAL +8 at 0x20.
    do_reset();
    decode_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 17'h20;
    step();
    redirect_valid = 1'b0;
    step();
    check("jal_req", 32'(icache_read_addr), 32'h20);
    icache_read_done = 1'b1; icache_read_data = 32'h0080_006F;
    step();
    icache_read_done = 1'b0;
    step();
`ifdef FETCH_JAL_PREDICT_EN
    check("jal_next", 32'(icache_read_addr), 32'h28);
`else
    check("jal_next", 32'(icache_read_addr), 32'h24);
`endif

    // Randomised traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rdy              = ($urandom % 10) != 0;
      redirect_valid   = ($urandom % 16) == 0;
      redirect_pc      = AW'($urandom) & 17'h1FFFC;
      decode_ready     = ($urandom % 3) != 0;
      icache_read_done = m_inflight && (($urandom % 3) == 0);
      icache_read_data = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
